fa_bist: RTL and testbench

- Synthesizable stimulus-and-check engine for the dual-rail synthesis full adder `fa`.
- Drives `fa` inputs through all 8 combinations of (x, y, cin) and samples sum/cout after a programmable settle window.
- Compares each sample against a golden x+y+cin result and reports pass/fail, the first failing vector and the error count.
- Sits opposite the adder: it owns the adder's inputs and consumes the adder's outputs, so adder netlists can be self-checked in hardware or in emulation.

---
 rtl/fa_bist_pkg.sv | 20 ++
 rtl/fa_bist_seq.sv | 43 ++++
 rtl/fa_bist.sv | 117 +++++++++++
 tb/tb_fa_bist.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fa_bist_pkg.sv
// Shared types and golden model for the full-adder BIST engine.
package fa_bist_pkg;

    localparam int NUM_VEC = 8;
    localparam int VEC_W   = 3;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } fa_bist_state_t;

    // Returns {cout, sum} for a single-bit full add.
    function automatic logic [1:0] fa_golden(input logic x, input logic y, input logic cin);
        return {1'b0, x} + {1'b0, y} + {1'b0, cin};
    endfunction

endpackage

// File: rtl/fa_bist_seq.sv
// Vector index and settle-window counter for fa_bist.
module fa_bist_seq
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             in_apply,
    input  logic             in_settle,
    output logic [VEC_W-1:0] vec,
    output logic             last_vec,
    output logic             settle_done
);

    logic [3:0] settle_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vec        <= '0;
            settle_cnt <= '0;
        end else begin
            if (clr)
                vec <= '0;
            else if (inc)
                vec <= vec + 1'b1;

            // Counter is 1 on the first SETTLE cycle so it reads SETTLE_CYCLES on the last.
            if (in_apply)
                settle_cnt <= 4'd1;
            else if (in_settle)
                settle_cnt <= settle_cnt + 4'd1;
            else
                settle_cnt <= '0;
        end
    end

    assign last_vec    = (vec == VEC_W'(NUM_VEC - 1));
    assign settle_done = (settle_cnt == 4'(SETTLE_CYCLES));

endmodule

// File: rtl/fa_bist.sv
// Exhaustive stimulus/check engine for a single-bit full adder: drives all
// 8 input vectors, samples after a settle window, reports pass/first-fail/count.
module fa_bist
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter bit STOP_ON_FAIL  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       dut_x,
    output logic       dut_y,
    output logic       dut_cin,
    input  logic       dut_sum,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_vec,
    output logic       fail_sum,
    output logic       fail_cout,
    output logic [3:0] err_count
);

    fa_bist_state_t   state, state_nxt;
    logic [VEC_W-1:0] vec;
    logic             last_vec, settle_done;
    logic             start_acc, in_apply, in_settle, in_check;
    logic             mismatch, finish, vec_inc;

    fa_bist_seq #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_seq (
        .clock       (clock),
        .reset       (reset),
        .clr         (start_acc),
        .inc         (vec_inc),
        .in_apply    (in_apply),
        .in_settle   (in_settle),
        .vec         (vec),
        .last_vec    (last_vec),
        .settle_done (settle_done)
    );

    // vec is a flop, so the adder inputs come straight from registers.
    assign dut_x   = vec[2];
    assign dut_y   = vec[1];
    assign dut_cin = vec[0];

    assign mismatch = ({dut_cout, dut_sum} != fa_golden(vec[2], vec[1], vec[0]));
    assign finish   = in_check && (last_vec || (mismatch && STOP_ON_FAIL));
    assign vec_inc  = in_check && !finish;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = APPLY;
            APPLY:      state_nxt = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
            SETTLE:     if (settle_done) state_nxt = CHECK;
            CHECK:      state_nxt = finish ? DONE : APPLY;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        start_acc = 1'b0;
        in_apply  = 1'b0;
        in_settle = 1'b0;
        in_check  = 1'b0;
        case (state)
            IDLE:    start_acc = start;
            APPLY:   begin busy = 1'b1; in_apply  = 1'b1; end
            SETTLE:  begin busy = 1'b1; in_settle = 1'b1; end
            CHECK:   begin busy = 1'b1; in_check  = 1'b1; end
            DONE:    begin done = 1'b1; start_acc = start; end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pass      <= 1'b0;
            fail_vec  <= '0;
            fail_sum  <= 1'b0;
            fail_cout <= 1'b0;
            err_count <= '0;
        end else if (start_acc) begin
            pass      <= 1'b0;
            fail_vec  <= '0;
            fail_sum  <= 1'b0;
            fail_cout <= 1'b0;
            err_count <= '0;
        end else if (in_check) begin
            if (mismatch) begin
                // A zero count means no earlier mismatch in this run.
                if (err_count == 4'd0) begin
                    fail_vec  <= vec;
                    fail_sum  <= dut_sum;
                    fail_cout <= dut_cout;
                end
                if (err_count != 4'd8)
                    err_count <= err_count + 4'd1;
            end
            if (finish)
                pass <= !mismatch && (err_count == 4'd0);
        end
    end

endmodule

// File: tb/tb_fa_bist.sv
// Bench for fa_bist: four engines with different settle/stop settings, each
// facing a table-driven adder model that may contain injected faults.
module tb_fa_bist;

    localparam int NI = 4;
    localparam int S_P [NI] = '{2, 2, 0, 5};
    localparam bit F_P [NI] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic       dx [NI], dy [NI], dc [NI], sum [NI], cout [NI];
    logic       busy [NI], done [NI], pass [NI], fsum [NI], fcout [NI];
    logic [2:0] fvec [NI];
    logic [3:0] errc [NI];
    logic [1:0] tbl [NI][8];

    int checks = 0;
    int errors = 0;

    int         exp_nvec [NI];
    int         exp_err [NI];
    logic [2:0] exp_fv [NI];
    logic [1:0] exp_fo [NI];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fa_bist #(.SETTLE_CYCLES(S_P[g]), .STOP_ON_FAIL(F_P[g])) u_dut (
            .clock     (clock),
            .reset     (reset),
            .start     (start),
            .dut_x     (dx[g]),
            .dut_y     (dy[g]),
            .dut_cin   (dc[g]),
            .dut_sum   (sum[g]),
            .dut_cout  (cout[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .pass      (pass[g]),
            .fail_vec  (fvec[g]),
            .fail_sum  (fsum[g]),
            .fail_cout (fcout[g]),
            .err_count (errc[g])
        );
        assign {cout[g], sum[g]} = tbl[g][{dx[g], dy[g], dc[g]}];
    end

    function automatic int golden(input int v);
        return ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
    endfunction

    // Expected outcome per engine from the adder table alone.
    function automatic void model();
        for (int i = 0; i < NI; i++) begin
            int nv, e;
            nv = 8;
            e  = 0;
            exp_fv[i] = 3'd0;
            exp_fo[i] = 2'd0;
            for (int v = 0; v < 8; v++) begin
                if (int'(tbl[i][v]) != golden(v)) begin
                    if (e == 0) begin
                        exp_fv[i] = 3'(v);
                        exp_fo[i] = tbl[i][v];
                    end
                    e++;
                    if (F_P[i]) begin
                        nv = v + 1;
                        break;
                    end
                end
            end
            exp_nvec[i] = nv;
            exp_err[i]  = e;
        end
    endfunction

    function automatic void fill_golden();
        for (int i = 0; i < NI; i++)
            for (int v = 0; v < 8; v++)
                tbl[i][v] = 2'(golden(v));
    endfunction

    task automatic run_case(input string name, input int repulse_k);
        int last;
        model();
        last = 0;
        for (int i = 0; i < NI; i++)
            if (exp_nvec[i] * (S_P[i] + 2) > last) last = exp_nvec[i] * (S_P[i] + 2);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 0; k <= last + 2; k++) begin
            start = (k + 1 == repulse_k);
            for (int i = 0; i < NI; i++) begin
                int de, ev;
                de = exp_nvec[i] * (S_P[i] + 2);
                ev = (k < de) ? k / (S_P[i] + 2) : exp_nvec[i] - 1;
                checks++;
                if (busy[i] !== (k < de)) begin
                    errors++;
                    $display("FAIL %s busy[%0d] k=%0d got %b exp %b", name, i, k, busy[i], k < de);
                end
                checks++;
                if (done[i] !== (k >= de)) begin
                    errors++;
                    $display("FAIL %s done[%0d] k=%0d got %b exp %b", name, i, k, done[i], k >= de);
                end
                checks++;
                if ({dx[i], dy[i], dc[i]} !== 3'(ev)) begin
                    errors++;
                    $display("FAIL %s vec[%0d] k=%0d got %b exp %0d", name, i, k, {dx[i], dy[i], dc[i]}, ev);
                end
                if (k == 0) begin
                    checks++;
                    if ({pass[i], fvec[i], fsum[i], fcout[i], errc[i]} !== 10'd0) begin
                        errors++;
                        $display("FAIL %s clear[%0d] got p=%b fv=%b fs=%b fc=%b err=%0d exp all 0",
                                 name, i, pass[i], fvec[i], fsum[i], fcout[i], errc[i]);
                    end
                end
                if (k == de) begin
                    checks++;
                    if (pass[i] !== (exp_err[i] == 0)) begin
                        errors++;
                        $display("FAIL %s pass[%0d] got %b exp %b", name, i, pass[i], exp_err[i] == 0);
                    end
                    checks++;
                    if (errc[i] !== 4'(exp_err[i])) begin
                        errors++;
                        $display("FAIL %s err_count[%0d] got %0d exp %0d", name, i, errc[i], exp_err[i]);
                    end
                    checks++;
                    if ({fvec[i], fcout[i], fsum[i]} !== {exp_fv[i], exp_fo[i]}) begin
                        errors++;
                        $display("FAIL %s fail_info[%0d] got vec=%b cout=%b sum=%b exp vec=%b cout=%b sum=%b",
                                 name, i, fvec[i], fcout[i], fsum[i], exp_fv[i], exp_fo[i][1], exp_fo[i][0]);
                    end
                end
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({dx[i], dy[i], dc[i], busy[i], done[i], pass[i], fvec[i], fsum[i], fcout[i], errc[i]} !== 15'd0) begin
                errors++;
                $display("FAIL reset_state[%0d] got busy=%b done=%b pass=%b err=%0d exp all 0",
                         i, busy[i], done[i], pass[i], errc[i]);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_clean();
        fill_golden();
        run_case("clean", -1);
    endtask

    task automatic test_sum_stuck0();
        fill_golden();
        for (int i = 0; i < NI; i++)
            for (int v = 0; v < 8; v++)
                tbl[i][v][0] = 1'b0;
        run_case("sum_sa0", -1);
    endtask

    task automatic test_back_to_back();
        fill_golden();
        run_case("restart_from_done", -1);
    endtask

    task automatic test_start_while_busy();
        fill_golden();
        run_case("start_busy", 5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            fill_golden();
            for (int i = 0; i < NI; i++)
                for (int v = 0; v < 8; v++)
                    if ($urandom_range(0, 3) == 0) tbl[i][v] = 2'($urandom_range(0, 3));
            run_case("random", -1);
        end
    endtask

    task automatic test_reset_midrun();
        fill_golden();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        // Engine 0 sits in SETTLE of vector 4 after edge 17.
        repeat (17) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({dx[i], dy[i], dc[i], busy[i], done[i], pass[i], fvec[i], fsum[i], fcout[i], errc[i]} !== 15'd0) begin
                errors++;
                $display("FAIL reset_midrun[%0d] got vec=%b busy=%b done=%b err=%0d exp all 0",
                         i, {dx[i], dy[i], dc[i]}, busy[i], done[i], errc[i]);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        run_case("after_reset", -1);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_sum_stuck0();
        test_back_to_back();
        test_start_while_busy();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
